// File: rtl/alu_display_pkg.sv
// rtl/alu_display_pkg.sv - shared constants, converter state type and segment lookup for alu_result_display
package alu_display_pkg;

  localparam int DIGIT_COUNT = 4;
  // One spare BCD digit beyond the display so values up to 16383 convert exactly
  localparam int BCD_W       = 20;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble converter, one bit per cycle, start/done handshake
module bin_to_bcd_seq
  import alu_display_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o
);

  conv_state_t       state_q;
  logic [DATA_W-1:0] sr_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj_d;
  logic [3:0]        cnt_q;

  // Add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: load on start, DATA_W shift cycles, one commit cycle; COMMIT may reload directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sr_q    <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj_d[BCD_W-2:0], sr_q[DATA_W-1]};
          sr_q  <= {sr_q[DATA_W-2:0], 1'b0};
          if (cnt_q == 4'(DATA_W - 1)) begin
            state_q <= COMMIT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        COMMIT: begin
          if (start_i) begin
            sr_q    <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == COMMIT);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result capture, BCD display register and 4-digit seven-segment scan (optional LEADING_ZERO_BLANK_EN)
module alu_result_display
  import alu_display_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SIGNED_MODE = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      result,
  input  logic                   result_valid,
  input  logic [1:0]             anode_driver,
  output logic [DIGIT_COUNT-1:0] an,
  output logic [6:0]             seg,
  output logic                   busy,
  output logic                   overflow
);

  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic              start_d;
  logic [DATA_W-1:0] src_raw_d;
  logic [DATA_W-1:0] src_mag_d;
  logic              src_neg_d;

  logic              pend_valid_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              conv_neg_q;

  logic [15:0]       disp_bcd_q;
  logic              disp_neg_q;
  logic              disp_ovf_q;

  logic [1:0]        sync1_q;
  logic [1:0]        sync2_q;
  logic [3:0]        an_q;
  logic [6:0]        seg_q;
  logic [3:0]        nib_d;
  logic              blank_d;
  logic [6:0]        seg_d;

  // Pick the conversion source and decide when to start: new strobes win over the pending buffer
  always_comb begin
    src_raw_d = result_valid ? result : pend_data_q;
    if (!conv_busy) begin
      start_d = result_valid;
    end else begin
      start_d = conv_done && (result_valid || pend_valid_q);
    end
    src_neg_d = (SIGNED_MODE != 0) && src_raw_d[DATA_W-1];
    src_mag_d = src_neg_d ? (~src_raw_d + 1'b1) : src_raw_d;
  end

  bin_to_bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bcd (
    .clk     (clock),
    .rst_n   (reset_n),
    .start_i (start_d),
    .bin_i   (src_mag_d),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // One-deep pending buffer and sign tracking for the conversion in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      conv_neg_q   <= 1'b0;
    end else begin
      if (start_d) begin
        conv_neg_q <= src_neg_d;
      end
      if (conv_busy && !conv_done && result_valid) begin
        pend_valid_q <= 1'b1;
        pend_data_q  <= result;
      end else if (start_d && conv_done) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  // Display register written in the COMMIT cycle; a spare BCD digit flags out-of-range values
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_ovf_q <= 1'b0;
    end else if (conv_done) begin
      disp_bcd_q <= conv_bcd[15:0];
      disp_neg_q <= conv_neg_q;
      disp_ovf_q <= conv_neg_q ? (conv_bcd[BCD_W-1:12] != '0)
                               : (conv_bcd[BCD_W-1:16] != '0);
    end
  end

  // Two-flop synchronizer on the scan counter select
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'd0;
      sync2_q <= 2'd0;
    end else begin
      sync1_q <= anode_driver;
      sync2_q <= sync1_q;
    end
  end

  // Segment pattern for the selected digit: overflow dashes, sign, optional leading-zero blanking
  always_comb begin
    nib_d   = disp_bcd_q[4*sync2_q +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    case (sync2_q)
      2'd1:    blank_d = (disp_bcd_q[15:4] == '0);
      2'd2:    blank_d = (disp_bcd_q[15:8] == '0);
      2'd3:    blank_d = (disp_bcd_q[15:12] == '0);
      default: blank_d = 1'b0;
    endcase
`else
    blank_d = 1'b0;
`endif
    if (disp_ovf_q) begin
      seg_d = SEG_DASH;
    end else if (sync2_q == 2'd3 && disp_neg_q) begin
      seg_d = SEG_MINUS;
    end else if (blank_d) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_of(nib_d);
    end
  end

  // Anode and cathode registers updated together so digit and anode never disagree
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << sync2_q);
      seg_q <= seg_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign busy     = conv_busy;
  assign overflow = disp_ovf_q;

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream consumer of the 2-bit digit-scan counter (anode_driver) on the ALU board.
- Captures each new ALU result and converts it to 4 BCD digits with a sequential double-dabble engine.
- Drives the active-low anodes and cathodes of a 4-digit seven-segment display, selecting the digit given by anode_driver.
- Handles sign display, overflow indication and one-deep buffering of results that arrive while a conversion is running.

Parameters:
- DATA_W, default 8: ALU result width. Legal range 4..14.
- SIGNED_MODE, default 1: when 1, result is two's complement.

Ports:
- clock, input, 1: system clock. anode_driver derives from the same clock.
- reset_n, input, 1: asynchronous active-low reset.
- result, input, DATA_W: ALU result.
- result_valid, input, 1: one-cycle strobe qualifying result.
- anode_driver, input, 2: digit select from the scan counter; stable for at least 4 clock cycles per value.
- an, output, 4: anode enables, active-low, registered.
- seg, output, 7: cathodes {g,f,e,d,c,b,a}, active-low, registered.
- busy, output, 1: conversion in progress.
- overflow, output, 1: displayed value is out of range.

Behaviour:
- Reset (asynchronous, any state): an=4'b1111, seg=7'h7F, busy=0, overflow=0, pending buffer empty. Display register = BCD 0, positive.
- Capture:
  - SIGNED_MODE=1: magnitude = |result| computed in DATA_W bits unsigned, so -2^(DATA_W-1) is correct; neg = result MSB.
  - SIGNED_MODE=0: magnitude = result; neg = 0.
- Converter FSM states and transitions:
  - IDLE -> SHIFT on start.
  - SHIFT runs exactly DATA_W cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift left one bit, bringing in the magnitude MSB.
  - SHIFT -> COMMIT.
  - COMMIT writes the display register (4 BCD nibbles, neg, overflow) in one cycle, then goes to IDLE, or straight to SHIFT if the pending buffer is full.
- busy = 1 in SHIFT and COMMIT.
- Latency: result_valid in IDLE at cycle 0 -> display register updated at the end of cycle DATA_W+1 -> an/seg reflect the new value on the next register update.
- Buffering: result_valid while busy stores result in a one-deep pending buffer.
  - A further valid while busy overwrites the buffer (newest wins).
  - A valid coincident with COMMIT also goes to the buffer.
  - The pending value starts in the cycle after COMMIT, with no idle cycle.
- Range:
  - Unsigned: overflow when magnitude > 9999.
  - Signed negative: overflow when magnitude > 999.
  - Overflow display: all four digits show dash (segment g only, seg=7'h3F).
- Digit mapping:
  - Digit k shows BCD nibble k.
  - When neg and not overflow, digit 3 shows minus (dash).
- Scan path:
  - anode_driver passes through 2 sync flops, then a registered decode.
  - an[k]=0 only for the synchronized select k.
  - seg updates in the same cycle as an, so there is never a mismatched digit/anode cycle.
  - Total latency from an anode_driver change to the an change is 3 cycles.
- Reset mid-conversion aborts the conversion, clears the pending buffer, and restores the reset display.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits are blanked (seg=7'h7F, anode still enabled). Digit 0 is never blanked. With neg, the minus stays on digit 3.
- Undefined: all four digits always show numerals or sign.

Decomposition:
- Package alu_display_pkg holds:
  - DIGIT_COUNT=4;
  - segment constants SEG_0..SEG_9, SEG_MINUS, SEG_DASH, SEG_BLANK;
  - FSM state typedef {IDLE, SHIFT, COMMIT}.
- Sub-module bin_to_bcd_seq: double-dabble FSM with start/done handshake, parameterised by DATA_W.
- Top level keeps: capture/pending buffer, display register, sync, digit decode.

Test Plan:
1. Hold reset_n=0 -> an=1111, seg=7F, busy=0. Release with anode_driver=0 -> after 3 cycles an=1110, seg=SEG_0.
2. DATA_W=8, SIGNED_MODE=1, result=123 strobed in IDLE -> busy high for cycles 1..9. Scanning anode_driver 0..3 then shows 3, 2, 1, then blank (macro on) or 0 (macro off).
3. result=8'hF6 (-10) -> digit3=SEG_MINUS, digit1=1, digit0=0, overflow=0. result=8'h80 -> digit3 minus, digits 1, 2, 8.
4. Valid 5 in IDLE, then valid 7 and valid 9 during SHIFT -> display shows 5, then 9. The value 7 never appears. busy stays high continuously across both conversions.
5. SIGNED_MODE=0, DATA_W=14, result=12000 -> overflow=1, all digits SEG_DASH. result=9999 -> overflow=0, digits 9, 9, 9, 9.
6. Assert reset_n during SHIFT with the pending buffer full -> immediate reset outputs. After release, no conversion resumes and the display shows 0.
